bank_burst_reader: RTL

Read-side counterpart of the 1-to-32 byte demultiplexer. The demux scatters received bytes into a 32-entry bank of 8-bit registers; this block gathers them back out. On a start command it streams a run of consecutive bank bytes, beginning at a given address, onto a valid/ready byte interface feeding the UART transmitter. It sits between the register bank and the serial TX path.

---
 rtl/bank_burst_reader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bank_burst_reader.sv
// bank_burst_reader
//   Streams a run of consecutive bytes out of a flattened 32 x 8-bit register
//   bank onto a valid/ready byte interface (UART TX side).
//
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     bank_in[255:0]   bank, byte k = bank_in[8k+7:8k]
//     start            burst request, only looked at while idle
//     start_addr[4:0]  first byte index of the burst (wraps 31 -> 0)
//     count[5:0]       bytes to send; 0 gives a done pulse with no data
//     tx_data[7:0]     byte offered to the transmitter
//     tx_valid         tx_data is valid
//     tx_ready         transmitter accepts tx_data this cycle
//     busy             burst in progress (includes the done cycle)
//     done             one-cycle pulse at the end of every accepted burst
//
//   Parameter INTER_GAP (0..15): idle cycles inserted between bytes.
module bank_burst_reader #(
    parameter int unsigned INTER_GAP = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] bank_in,
    input  logic         start,
    input  logic [4:0]   start_addr,
    input  logic [5:0]   count,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    localparam logic [3:0] GAP_LOAD = 4'(INTER_GAP);

    state_t      r_state;
    logic [4:0]  r_addr;
    logic [5:0]  r_rem;
    logic [3:0]  r_gap;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_busy;
    logic        r_done;

    logic [4:0]  w_addr_nxt;

    assign w_addr_nxt = r_addr + 5'd1;   // natural 5-bit wrap 31 -> 0

    function automatic logic [7:0] f_byte(input logic [255:0] bank, input logic [4:0] idx);
        return bank[{idx, 3'b000} +: 8];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_gap   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (count != 6'd0) begin
                            r_addr  <= start_addr;
                            r_rem   <= count;
                            r_data  <= f_byte(bank_in, start_addr);
                            r_valid <= 1'b1;
                            r_state <= S_SEND;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_SEND: begin
                    // data is held in r_data until the handshake, so bank
                    // changes during a stall never reach the transmitter
                    if (tx_ready) begin
                        if (r_rem == 6'd1) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_addr <= w_addr_nxt;
                            r_rem  <= r_rem - 6'd1;
                            if (INTER_GAP == 0) begin
                                r_data <= f_byte(bank_in, w_addr_nxt);
                            end else begin
                                r_valid <= 1'b0;
                                r_gap   <= GAP_LOAD;
                                r_state <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    // next byte sampled on the last gap cycle so late bank
                    // updates made during the gap are picked up
                    if (r_gap == 4'd1) begin
                        r_gap   <= '0;
                        r_data  <= f_byte(bank_in, r_addr);
                        r_valid <= 1'b1;
                        r_state <= S_SEND;
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_data  = r_data;
    assign tx_valid = r_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
